fifo_flags: RTL and testbench

- Synchronous FIFO with programmable almost-full/almost-empty thresholds and an error flag.
- One instance per buffer in the transaction path: Main FIFO, VC0/VC1 FIFOs, D0/D1 FIFOs.
- Its empty/error/threshold outputs are concatenated into the FIFO_empties[4:0] and FIFO_errors[4:0] buses consumed by the control FSM (idle/active/error).
- Threshold inputs are the per-FIFO-type values the FSM latches during init (afMFs/aeMFs, afVCs/aeVCs, afDs/aeDs).

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_flags_mem_dp.sv | 27 ++
 rtl/fifo_flags.sv | 79 +++++++
 tb/tb_fifo_flags.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and FIFO bus ordering for the fifo_flags buffers
package fifo_pkg;
    localparam int FIFO_DATA_WIDTH = 6;
    localparam int FIFO_ADDR_WIDTH = 3;
    localparam int FIFO_DEPTH      = 2**FIFO_ADDR_WIDTH;
    // Bit positions of each buffer in FIFO_empties[4:0] / FIFO_errors[4:0]
    typedef enum logic [2:0] {
        MAIN = 3'd0,
        VC0  = 3'd1,
        VC1  = 3'd2,
        D0   = 3'd3,
        D1   = 3'd4
    } fifo_idx_e;
endpackage

// File: rtl/fifo_flags_mem_dp.sv
// mem_dp: DW x 2**AW register array, sync write on we, registered read on re
// Ports: clk, rst_n (clears only the read register), we/waddr/wdata write port,
//        re/raddr read port, rdata registered read data (holds when re=0).
module mem_dp
    import fifo_pkg::*;
#(
    parameter int DW = FIFO_DATA_WIDTH,
    parameter int AW = FIFO_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;
    always_ff @(posedge clk)
        if (we) r_mem[waddr] <= wdata;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_rdata <= '0;
        else if (re) r_rdata <= r_mem[raddr];
    assign rdata = r_rdata;
endmodule

// File: rtl/fifo_flags.sv
// fifo_flags: synchronous FIFO with programmable almost-full/almost-empty flags and error
// Ports: clk, reset_L (async active-low), push/pop requests, data_in write data,
//        umbral_alto/umbral_bajo thresholds, data_out/valid_out registered read,
//        full/empty/almost_full/almost_empty flags, fifo_error, count occupancy.
// Build option FIFO_ERR_STICKY_EN: fifo_error latches until reset instead of pulsing.
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] umbral_alto,
    input  logic [ADDR_WIDTH-1:0] umbral_bajo,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  fifo_error,
    output logic [ADDR_WIDTH:0]   count
);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count, w_count_nxt;
    logic                  r_valid, r_err;
    logic                  w_full, w_empty, w_push_ok, w_pop_ok, w_err_evt;
    assign w_full    = r_count == CNT_FULL;
    assign w_empty   = r_count == '0;
    // A pop frees a slot on the same edge, so push at full is accepted alongside it
    assign w_push_ok = push && (!w_full || pop);
    assign w_pop_ok  = pop && !w_empty;
    assign w_err_evt = (push && w_full && !pop) || (pop && w_empty);
    always_comb
        w_count_nxt = (w_push_ok && !w_pop_ok) ? r_count + CNT_ONE :
                      (w_pop_ok && !w_push_ok) ? r_count - CNT_ONE : r_count;
    always_ff @(posedge clk or negedge reset_L)
        if (!reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_wr_ptr <= w_push_ok ? r_wr_ptr + PTR_ONE : r_wr_ptr;
            r_rd_ptr <= w_pop_ok ? r_rd_ptr + PTR_ONE : r_rd_ptr;
            r_count  <= w_count_nxt;
            r_valid  <= w_pop_ok;
`ifdef FIFO_ERR_STICKY_EN
            r_err    <= r_err | w_err_evt;
`else
            r_err    <= w_err_evt;
`endif
        end
    mem_dp #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_mem (
        .clk   (clk),
        .rst_n (reset_L),
        .we    (w_push_ok),
        .waddr (r_wr_ptr),
        .wdata (data_in),
        .re    (w_pop_ok),
        .raddr (r_rd_ptr),
        .rdata (data_out)
    );
    assign valid_out    = r_valid;
    assign fifo_error   = r_err;
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = r_count >= {1'b0, umbral_alto};
    assign almost_empty = r_count <= {1'b0, umbral_bajo};
endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: randomized + directed scoreboard bench for fifo_flags
module tb_fifo_flags;
    logic       clk = 1'b0;
    logic       reset_L, push, pop;
    logic [5:0] data_in, data_out;
    logic [2:0] ua, ub;
    logic       valid_out, full, empty, almost_full, almost_empty, fifo_error;
    logic [3:0] count;

    int n_chk = 0;
    int n_pass = 0;
    int mq[$];
    int exp_q[$];
    bit m_err = 0;
    bit m_valid = 0;

    fifo_flags dut (
        .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .data_in(data_in),
        .umbral_alto(ua), .umbral_bajo(ub), .data_out(data_out), .valid_out(valid_out),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .fifo_error(fifo_error), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic check_state();
        int n = mq.size();
        chk("count", int'(count), n);
        chk("empty", int'(empty), int'(n == 0));
        chk("full", int'(full), int'(n == 8));
        chk("almost_full", int'(almost_full), int'(n >= int'(ua)));
        chk("almost_empty", int'(almost_empty), int'(n <= int'(ub)));
        chk("valid_out", int'(valid_out), int'(m_valid));
        chk("fifo_error", int'(fifo_error), int'(m_err));
    endtask

    // One clock of stimulus; the reference model applies the FIFO rules to a queue
    task automatic cyc(input bit p, input bit q, input int d);
        bit was_full, was_empty, evt;
        @(negedge clk);
        check_state();
        push = p;
        pop = q;
        data_in = 6'(d);
        was_full = mq.size() == 8;
        was_empty = mq.size() == 0;
        evt = (p && was_full && !q) || (q && was_empty);
        m_valid = q && !was_empty;
        if (m_valid) exp_q.push_back(mq.pop_front());
        if (p && (!was_full || q)) mq.push_back(d & 63);
`ifdef FIFO_ERR_STICKY_EN
        m_err = m_err | evt;
`else
        m_err = evt;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_state();
        push = 0;
        pop = 0;
        #2 reset_L = 0;
        #1;
        mq.delete();
        exp_q.delete();
        m_err = 0;
        m_valid = 0;
        check_state();
        @(negedge clk);
        #2 reset_L = 1;
    endtask

    always @(negedge clk) begin
        int e;
        if (reset_L === 1'b1 && valid_out === 1'b1) begin
            if (exp_q.size() == 0) chk("spurious_valid", int'(valid_out), 0);
            else begin
                e = exp_q.pop_front();
                chk("data_out", int'(data_out), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        reset_L = 0; push = 0; pop = 0; data_in = 0; ua = 3'd6; ub = 3'd1;
        repeat (2) @(negedge clk);
        #2 reset_L = 1;
        cyc(0, 0, 0);
        cyc(1, 0, 9);
        cyc(1, 0, 10);
        do_reset();
        // Fill 1..8, then overflow with 0x3F, idle, drain
        for (int i = 1; i <= 8; i++) cyc(1, 0, i);
        cyc(1, 0, 'h3F);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0);
        cyc(0, 0, 0);
        do_reset();
        // Refill, then push+pop at full
        for (int i = 0; i < 8; i++) cyc(1, 0, 'h11 + i);
        for (int i = 0; i < 4; i++) cyc(1, 1, 'h2A);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0);
        cyc(0, 0, 0);
        // Underflow, push+pop at empty, then wrap with occupancy 0..3
        cyc(0, 1, 0);
        cyc(1, 1, 5);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        w = 0;
        while (w < 20) begin
            for (int k = 0; k < 3 && w < 20; k++) begin
                cyc(1, 0, 'h20 + w);
                w++;
            end
            while (mq.size() > 0) cyc(0, 1, 0);
        end
        cyc(0, 0, 0);
        // Reset mid-fill
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, 'h30 + i);
        do_reset();
        cyc(1, 0, 'h15);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        // Randomized traffic with changing thresholds
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                ua = 3'($urandom_range(0, 7));
                ub = 3'($urandom_range(0, 7));
            end
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
        end
        ua = 3'd0;
        ub = 3'd7;
        repeat (10) cyc(0, 1, 0);
        repeat (3) cyc(0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
